// File: rtl/dff_compare_pkg.sv
// Shared types and defaults for the golden-vs-netlist DFF comparison monitor.
package dff_compare_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dff_compare_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dff_compare_monitor.sv
// Compares a golden DFF output against its post-route netlist over a run of
// strobed samples, tracking match/mismatch counts and the first failing index.
module dff_compare_monitor
    import dff_compare_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic [CNT_W-1:0] i_Total,
    input  logic             i_Sample,
    input  logic             i_Golden,
    input  logic             i_Netlist,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Pass,
    output logic             o_ResultValid,
    output logic             o_Match,
    output logic [CNT_W-1:0] o_CompareCount,
    output logic [CNT_W-1:0] o_MismatchCount,
    output logic [CNT_W-1:0] o_FirstFailIdx,
    output logic             o_FirstFailValid
);

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] total_q,       total_d;
    logic [CNT_W-1:0] cmp_cnt_q,     cmp_cnt_d;
    logic [CNT_W-1:0] first_idx_q,   first_idx_d;
    logic             first_valid_q, first_valid_d;
    logic             match_q,       match_d;
    logic             rvalid_q,      rvalid_d;
    logic             mis_clr;
    logic             mis_inc;
    logic             is_match;

    assign is_match = (i_Golden == i_Netlist);

    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        cmp_cnt_d     = cmp_cnt_q;
        first_idx_d   = first_idx_q;
        first_valid_d = first_valid_q;
        match_d       = match_q;
        rvalid_d      = 1'b0;
        mis_clr       = 1'b0;
        mis_inc       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A start here wins over any coincident sample, which is dropped.
                if (i_Start) begin
                    total_d       = i_Total;
                    cmp_cnt_d     = '0;
                    first_idx_d   = '0;
                    first_valid_d = 1'b0;
                    match_d       = 1'b0;
                    mis_clr       = 1'b1;
                    state_d       = (i_Total == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_Sample && (cmp_cnt_q < total_q)) begin
                    rvalid_d  = 1'b1;
                    match_d   = is_match;
                    cmp_cnt_d = cmp_cnt_q + 1'b1;
                    if (!is_match) begin
                        mis_inc = 1'b1;
                        if (!first_valid_q) begin
                            first_idx_d   = cmp_cnt_q;
                            first_valid_d = 1'b1;
                        end
                    end
                    if (cmp_cnt_d == total_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            total_q       <= '0;
            cmp_cnt_q     <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
            match_q       <= 1'b0;
            rvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            cmp_cnt_q     <= cmp_cnt_d;
            first_idx_q   <= first_idx_d;
            first_valid_q <= first_valid_d;
            match_q       <= match_d;
            rvalid_q      <= rvalid_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_mismatch_cnt (
        .clk     (clk),
        .srst_i  (i_Reset),
        .clr_i   (mis_clr),
        .inc_i   (mis_inc),
        .count_o (o_MismatchCount)
    );

    assign o_Busy           = (state_q == ST_RUN);
    assign o_Done           = (state_q == ST_DONE);
    assign o_Pass           = (state_q == ST_DONE) && (o_MismatchCount == '0);
    assign o_ResultValid    = rvalid_q;
    assign o_Match          = match_q;
    assign o_CompareCount   = cmp_cnt_q;
    assign o_FirstFailIdx   = first_idx_q;
    assign o_FirstFailValid = first_valid_q;

endmodule

// File: tb/tb_dff_compare_monitor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based model of accepted sample results.
module tb_dff_compare_monitor;

    localparam int W = 4;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         i_Reset = 1'b0;
    logic         i_Start = 1'b0;
    logic [W-1:0] i_Total = '0;
    logic         i_Sample = 1'b0;
    logic         i_Golden = 1'b0;
    logic         i_Netlist = 1'b0;
    logic         o_Busy, o_Done, o_Pass, o_ResultValid, o_Match, o_FirstFailValid;
    logic [W-1:0] o_CompareCount, o_MismatchCount, o_FirstFailIdx;

    int total_checks = 0;
    int bad = 0;

    // Model: phase 0 = idle, 1 = running, 2 = finished; m_res holds match bits.
    int m_phase = 0;
    int m_total = 0;
    bit m_res[$];
    bit exp_rv = 0;
    bit exp_match = 0;

    dff_compare_monitor #(.CNT_W(W)) dut (
        .clk              (clk),
        .i_Reset          (i_Reset),
        .i_Start          (i_Start),
        .i_Total          (i_Total),
        .i_Sample         (i_Sample),
        .i_Golden         (i_Golden),
        .i_Netlist        (i_Netlist),
        .o_Busy           (o_Busy),
        .o_Done           (o_Done),
        .o_Pass           (o_Pass),
        .o_ResultValid    (o_ResultValid),
        .o_Match          (o_Match),
        .o_CompareCount   (o_CompareCount),
        .o_MismatchCount  (o_MismatchCount),
        .o_FirstFailIdx   (o_FirstFailIdx),
        .o_FirstFailValid (o_FirstFailValid)
    );

    always #5 clk = ~clk;

    function automatic int exp_cmp();
        return m_res.size();
    endfunction

    function automatic int exp_mis();
        int c = 0;
        foreach (m_res[k]) if (!m_res[k]) c++;
        return (c > MAXC) ? MAXC : c;
    endfunction

    function automatic int exp_fidx();
        foreach (m_res[k]) if (!m_res[k]) return k;
        return 0;
    endfunction

    function automatic bit exp_fvalid();
        foreach (m_res[k]) if (!m_res[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input bit rst, input bit st, input int tot,
                        input bit smp, input bit g, input bit n);
        i_Reset = rst; i_Start = st; i_Total = W'(tot);
        i_Sample = smp; i_Golden = g; i_Netlist = n;
        @(posedge clk);
        #1;
        exp_rv = 1'b0;
        if (rst) begin
            m_phase = 0; m_total = 0; m_res.delete(); exp_match = 1'b0;
        end else if (st && m_phase != 1) begin
            m_total = tot; m_res.delete(); exp_match = 1'b0;
            m_phase = (tot == 0) ? 2 : 1;
        end else if (m_phase == 1 && smp && m_res.size() < m_total) begin
            m_res.push_back(g == n);
            exp_rv = 1'b1;
            exp_match = (g == n);
            if (m_res.size() == m_total) m_phase = 2;
        end
        i_Reset = 1'b0; i_Start = 1'b0; i_Sample = 1'b0;
        $display("txn t=%0t rst=%0b start=%0b tot=%0d smp=%0b g=%0b n=%0b -> busy=%0b done=%0b cnt=%0d mis=%0d",
                 $time, rst, st, tot, smp, g, n, o_Busy, o_Done, o_CompareCount, o_MismatchCount);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        total_checks++;
        if ({o_Busy, o_Done, o_Pass, o_ResultValid, o_Match, o_FirstFailValid} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=000000",
                {o_Busy, o_Done, o_Pass, o_ResultValid, o_Match, o_FirstFailValid});
        end
        total_checks++;
        if ({o_CompareCount, o_MismatchCount, o_FirstFailIdx} !== 12'h000) begin
            bad++; $display("FAIL reset_counts got=%h want=000",
                {o_CompareCount, o_MismatchCount, o_FirstFailIdx});
        end
    endtask

    task automatic test_mid_run_reset();
        step(0, 1, 10, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 1, k[0]);
        total_checks++;
        if (o_Busy !== 1'b1 || o_CompareCount !== 4'd4) begin
            bad++; $display("FAIL midrun_before busy=%b cnt=%0d want busy=1 cnt=4", o_Busy, o_CompareCount);
        end
        step(1, 0, 0, 1, 1, 0);
        total_checks++;
        if ({o_Busy, o_Done, o_Pass, o_ResultValid, o_Match, o_FirstFailValid,
             o_CompareCount, o_MismatchCount, o_FirstFailIdx} !== 18'b0) begin
            bad++; $display("FAIL midrun_reset got=%h want=0",
                {o_Busy, o_Done, o_Pass, o_ResultValid, o_Match, o_FirstFailValid,
                 o_CompareCount, o_MismatchCount, o_FirstFailIdx});
        end
    endtask

    task automatic test_all_match();
        step(0, 1, 6, 0, 0, 0);
        total_checks++;
        if (o_Busy !== 1'b1 || o_Done !== 1'b0) begin
            bad++; $display("FAIL allmatch_busy busy=%b done=%b want 1/0", o_Busy, o_Done);
        end
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 1, 1, 1);
            total_checks++;
            if (o_ResultValid !== 1'b1 || o_Match !== 1'b1 || o_CompareCount !== 4'(k + 1)) begin
                bad++; $display("FAIL allmatch_sample%0d rv=%b m=%b cnt=%0d want 1/1/%0d",
                                k, o_ResultValid, o_Match, o_CompareCount, k + 1);
            end
        end
        total_checks++;
        if (o_Done !== 1'b1 || o_Pass !== 1'b1 || o_Busy !== 1'b0 || o_MismatchCount !== 4'd0
            || o_FirstFailValid !== 1'b0) begin
            bad++; $display("FAIL allmatch_final done=%b pass=%b busy=%b mis=%0d fv=%b want 1/1/0/0/0",
                            o_Done, o_Pass, o_Busy, o_MismatchCount, o_FirstFailValid);
        end
        step(0, 0, 0, 0, 0, 0);
        total_checks++;
        if (o_ResultValid !== 1'b0 || o_Done !== 1'b1) begin
            bad++; $display("FAIL allmatch_hold rv=%b done=%b want 0/1", o_ResultValid, o_Done);
        end
    endtask

    task automatic test_mismatch();
        step(0, 1, 5, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1, (k == 2 || k == 4) ? 1'b0 : 1'b1);
        total_checks++;
        if (o_MismatchCount !== 4'd2 || o_FirstFailIdx !== 4'd2 || o_FirstFailValid !== 1'b1
            || o_Pass !== 1'b0 || o_Done !== 1'b1 || o_CompareCount !== 4'd5 || o_Match !== 1'b0) begin
            bad++; $display("FAIL mismatch_final mis=%0d idx=%0d fv=%b pass=%b done=%b cnt=%0d m=%b want 2/2/1/0/1/5/0",
                            o_MismatchCount, o_FirstFailIdx, o_FirstFailValid, o_Pass, o_Done,
                            o_CompareCount, o_Match);
        end
    endtask

    task automatic test_zero_total();
        step(0, 1, 0, 0, 0, 0);
        total_checks++;
        if (o_Done !== 1'b1 || o_Pass !== 1'b1 || o_Busy !== 1'b0) begin
            bad++; $display("FAIL zero_total done=%b pass=%b busy=%b want 1/1/0", o_Done, o_Pass, o_Busy);
        end
        step(0, 1, 3, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0, 0);
        total_checks++;
        if (o_CompareCount !== 4'd3 || o_ResultValid !== 1'b0 || o_Done !== 1'b1) begin
            bad++; $display("FAIL extra_samples cnt=%0d rv=%b done=%b want 3/0/1",
                            o_CompareCount, o_ResultValid, o_Done);
        end
    endtask

    task automatic test_saturation();
        step(0, 1, 15, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            // A start raised mid-run must not restart the counters.
            step(0, (k == 7), 2, 1, 0, 1);
        end
        total_checks++;
        if (o_MismatchCount !== 4'd15 || o_CompareCount !== 4'd15 || o_Done !== 1'b1
            || o_FirstFailIdx !== 4'd0 || o_Pass !== 1'b0) begin
            bad++; $display("FAIL saturation mis=%0d cnt=%0d done=%b idx=%0d pass=%b want 15/15/1/0/0",
                            o_MismatchCount, o_CompareCount, o_Done, o_FirstFailIdx, o_Pass);
        end
    endtask

    task automatic test_restart();
        step(0, 1, 4, 1, 1, 0);
        total_checks++;
        if (o_Done !== 1'b0 || o_Busy !== 1'b1 || o_CompareCount !== 4'd0 || o_MismatchCount !== 4'd0
            || o_ResultValid !== 1'b0 || o_FirstFailValid !== 1'b0 || o_Match !== 1'b0) begin
            bad++; $display("FAIL restart done=%b busy=%b cnt=%0d mis=%0d rv=%b fv=%b m=%b want 0/1/0/0/0/0/0",
                            o_Done, o_Busy, o_CompareCount, o_MismatchCount, o_ResultValid,
                            o_FirstFailValid, o_Match);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            step(($urandom % 80) == 0, ($urandom % 10) == 0, $urandom_range(0, 9),
                 ($urandom % 4) != 0, $urandom % 2, $urandom % 2);
            total_checks++;
            if (o_Busy !== (m_phase == 1) || o_Done !== (m_phase == 2)
                || o_Pass !== (m_phase == 2 && exp_mis() == 0)) begin
                bad++; $display("FAIL rand_state c=%0d busy=%b done=%b pass=%b phase=%0d mis=%0d",
                                c, o_Busy, o_Done, o_Pass, m_phase, exp_mis());
            end
            total_checks++;
            if (o_ResultValid !== exp_rv || o_Match !== exp_match) begin
                bad++; $display("FAIL rand_result c=%0d rv=%b m=%b want %b/%b",
                                c, o_ResultValid, o_Match, exp_rv, exp_match);
            end
            total_checks++;
            if (o_CompareCount !== W'(exp_cmp()) || o_MismatchCount !== W'(exp_mis())
                || o_FirstFailValid !== exp_fvalid() || o_FirstFailIdx !== W'(exp_fidx())) begin
                bad++; $display("FAIL rand_counts c=%0d cnt=%0d mis=%0d fv=%b idx=%0d want %0d/%0d/%b/%0d",
                                c, o_CompareCount, o_MismatchCount, o_FirstFailValid, o_FirstFailIdx,
                                exp_cmp(), exp_mis(), exp_fvalid(), exp_fidx());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mid_run_reset();
        test_all_match();
        test_mismatch();
        test_zero_total();
        test_saturation();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end

endmodule

// File: doc/dff_compare_monitor.md
DFF_COMPARE_MONITOR -- requirements
Module: dff_compare_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all counters and indices.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port i_Reset  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port i_Start  input  1: one-cycle pulse that starts a comparison run.
REQ-005 SHALL have port i_Total  input  CNT_W: number of comparisons in the run, latched on accepted i_Start.
REQ-006 SHALL have port i_Sample  input  1: strobe; compare i_Golden vs i_Netlist this cycle.
REQ-007 SHALL have port i_Golden  input  1: reference-design output (o_Q of golden dffre_inst).
REQ-008 SHALL have port i_Netlist  input  1: post-route-netlist output.
REQ-009 SHALL have port o_Busy  output  1: run in progress.
REQ-010 SHALL have port o_Done  output  1: run complete; held until next accepted i_Start or reset.
REQ-011 SHALL have port o_Pass  output  1: valid while o_Done; 1 iff o_MismatchCount == 0.
REQ-012 SHALL have port o_ResultValid  output  1: one-cycle pulse per accepted sample.
REQ-013 SHALL have port o_Match  output  1: result of the last accepted sample; qualified by o_ResultValid.
REQ-014 SHALL have port o_CompareCount  output  CNT_W: samples accepted in the current run.
REQ-015 SHALL have port o_MismatchCount  output  CNT_W: mismatching samples, saturating.
REQ-016 SHALL have port o_FirstFailIdx  output  CNT_W: 0-based index of first mismatching sample.
REQ-017 SHALL have port o_FirstFailValid  output  1: o_FirstFailIdx holds a captured value.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 IDLE + i_Start: SHALL latch i_Total, clear all counters, o_FirstFailValid and o_Match, and go to RUN; if i_Total == 0, go directly to DONE with o_Pass=1.
REQ-020 RUN: i_Sample SHALL be accepted only while o_CompareCount < latched total; i_Sample in IDLE or DONE SHALL be ignored.
REQ-021 An accepted sample in cycle N SHALL produce o_ResultValid=1, o_Match=(i_Golden==i_Netlist) and updated counters in cycle N+1 (1-cycle latency).
REQ-022 On a mismatch, o_MismatchCount SHALL increment and saturate at 2^CNT_W-1, without wrapping.
REQ-023 On the first mismatch of a run, SHALL capture o_FirstFailIdx = pre-increment o_CompareCount and set o_FirstFailValid; later mismatches SHALL NOT overwrite it.
REQ-024 On the edge that registers the final sample, SHALL go to DONE; o_Done, o_Pass and final counts SHALL be visible together in cycle N+1.
REQ-025 i_Start during RUN SHALL be ignored; i_Start during DONE SHALL restart exactly as from IDLE, with o_Done deasserting in the next cycle.
REQ-026 o_Busy SHALL be 1 exactly in RUN; o_Done SHALL be 1 exactly in DONE.
REQ-027 Simultaneous i_Start and i_Sample in IDLE or DONE: SHALL start the run and discard the sample.

Reset
REQ-028 i_Reset SHALL take priority over all inputs and force IDLE, including mid-run.
REQ-029 Reset values SHALL be: o_Busy=0, o_Done=0, o_Pass=0, o_ResultValid=0, o_Match=0, all counts 0, o_FirstFailIdx=0, o_FirstFailValid=0.

Structure
REQ-030 Package dff_compare_pkg SHALL hold the state enum and the default CNT_W constant.
REQ-031 SHALL instantiate sub-module sat_counter (CNT_W wide; clear, increment, saturate) for o_MismatchCount.
REQ-032 SHALL be synthesizable, with no X-dependent logic; estimated size is 150-250 RTL lines.

Verification
REQ-033 Reset mid-run: i_Total=10, 4 samples, then i_Reset -> next cycle IDLE, all outputs 0.
REQ-034 All match: i_Total=6, 6 samples with Golden=Netlist=1 -> o_Done=1, o_Pass=1, counts 6/0, o_FirstFailValid=0.
REQ-035 Mismatch: i_Total=5, mismatches at samples 2 and 4 -> MismatchCount=2, FirstFailIdx=2, o_Pass=0.
REQ-036 Boundary: i_Total=0 -> DONE one cycle after i_Start with o_Pass=1; extra samples after completion leave CompareCount=i_Total.
REQ-037 Saturation: CNT_W=4, i_Total=15, all 15 mismatch -> MismatchCount=15, no wrap; i_Start in RUN ignored.
REQ-038 Restart from DONE: i_Start together with i_Sample -> counts cleared, sample discarded, o_Done low next cycle.
